// File: rtl/mlu_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module  : mlu_operand_feeder
// Brief   : Walks HotBuf/ColdBuf in (hot, cold, chunk) loop order and streams
//           paired 16-lane operand vectors to the MLU with first/last tags,
//           valid/ready backpressure and a 2-entry fall-through output queue.
//           Optional stall counter output enabled by macro MLU_FEED_PERF_EN.
// Rev     : 1.0  initial release
// ============================================================================
module mlu_operand_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ADDR_WIDTH-1:0]         hot_base,
  input  logic [ADDR_WIDTH-1:0]         cold_base,
  input  logic [CNT_WIDTH-1:0]          num_hot,
  input  logic [CNT_WIDTH-1:0]          num_cold,
  input  logic [CNT_WIDTH-1:0]          dim_chunks,
  output logic                          hot_rd_en,
  output logic [ADDR_WIDTH-1:0]         hot_rd_addr,
  input  logic [16*DATA_WIDTH-1:0]      hot_rd_data,
  output logic                          cold_rd_en,
  output logic [ADDR_WIDTH-1:0]         cold_rd_addr,
  input  logic [16*DATA_WIDTH-1:0]      cold_rd_data,
  output logic [15:0][DATA_WIDTH-1:0]   hot_out,
  output logic [15:0][DATA_WIDTH-1:0]   cold_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_first,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done
`ifdef MLU_FEED_PERF_EN
  ,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int c_vec_w   = 16 * DATA_WIDTH;
  localparam int c_entry_w = 2 * c_vec_w + 2;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_run   = 2'd1;
  localparam logic [1:0] c_st_drain = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  c_cnt_one  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  c_cnt_zero = {CNT_WIDTH{1'b0}};

  logic [1:0]            state_q, state_d;

  logic [ADDR_WIDTH-1:0] cold_base_q, cold_base_d;
  logic [CNT_WIDTH-1:0]  num_hot_q, num_hot_d;
  logic [CNT_WIDTH-1:0]  num_cold_q, num_cold_d;
  logic [CNT_WIDTH-1:0]  dim_q, dim_d;
  logic [CNT_WIDTH-1:0]  h_q, h_d;
  logic [CNT_WIDTH-1:0]  c_q, c_d;
  logic [CNT_WIDTH-1:0]  d_q, d_d;
  // hot_row_q holds hot_base + h*dim_chunks, the start of the current hot vector
  logic [ADDR_WIDTH-1:0] hot_row_q, hot_row_d;
  logic [ADDR_WIDTH-1:0] hot_addr_q, hot_addr_d;
  logic [ADDR_WIDTH-1:0] cold_addr_q, cold_addr_d;

  logic                  inflight_q, inflight_d;
  logic                  tag_first_q, tag_first_d;
  logic                  tag_last_q, tag_last_d;

  logic [c_entry_w-1:0]  mem_q [2];
  logic [c_entry_w-1:0]  mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;

  logic                  room;
  logic                  issue;
  logic                  d_last, c_last, h_last;
  logic                  final_issue;
  logic                  cfg_zero;
  logic                  bypass;
  logic                  pop;
  logic                  q_wr;
  logic                  q_rd;
  logic [c_entry_w-1:0]  entry_in;
  logic [c_entry_w-1:0]  head;

  // Read-issue and loop-boundary decode
  assign d_last      = (d_q == dim_q - c_cnt_one);
  assign c_last      = (c_q == num_cold_q - c_cnt_one);
  assign h_last      = (h_q == num_hot_q - c_cnt_one);
  assign room        = (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2);
  assign issue       = (state_q == c_st_run) && room;
  assign final_issue = issue && d_last && c_last && h_last;
  assign cfg_zero    = (num_hot == c_cnt_zero) || (num_cold == c_cnt_zero) ||
                       (dim_chunks == c_cnt_zero);

  // Queue head: with the queue empty, returning read data falls straight through
  assign bypass    = (count_q == 2'd0) && inflight_q;
  assign out_valid = (count_q != 2'd0) || inflight_q;
  assign pop       = out_valid && out_ready;
  assign q_wr      = inflight_q && !(bypass && pop);
  assign q_rd      = pop && (count_q != 2'd0);
  assign entry_in  = {tag_first_q, tag_last_q, cold_rd_data, hot_rd_data};
  assign head      = bypass ? entry_in : mem_q[rd_ptr_q];

  assign hot_out      = head[c_vec_w-1:0];
  assign cold_out     = head[2*c_vec_w-1:c_vec_w];
  assign out_first    = head[c_entry_w-1];
  assign out_last     = head[c_entry_w-2];
  assign hot_rd_addr  = hot_addr_q;
  assign cold_rd_addr = cold_addr_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: begin
        if (start) begin
          state_d = cfg_zero ? c_st_done : c_st_run;
        end
      end
      c_st_run: begin
        if (final_issue) begin
          state_d = c_st_drain;
        end
      end
      c_st_drain: begin
        if (count_d == 2'd0) begin
          state_d = c_st_done;
        end
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    hot_rd_en  = issue;
    cold_rd_en = issue;
    busy       = (state_q == c_st_run) || (state_q == c_st_drain);
    done       = (state_q == c_st_done);
  end

  // Config latch, loop counters and incremental address generation
  always_comb begin
    cold_base_d = cold_base_q;
    num_hot_d   = num_hot_q;
    num_cold_d  = num_cold_q;
    dim_d       = dim_q;
    h_d         = h_q;
    c_d         = c_q;
    d_d         = d_q;
    hot_row_d   = hot_row_q;
    hot_addr_d  = hot_addr_q;
    cold_addr_d = cold_addr_q;
    if ((state_q == c_st_idle) && start) begin
      cold_base_d = cold_base;
      num_hot_d   = num_hot;
      num_cold_d  = num_cold;
      dim_d       = dim_chunks;
      h_d         = c_cnt_zero;
      c_d         = c_cnt_zero;
      d_d         = c_cnt_zero;
      hot_row_d   = hot_base;
      hot_addr_d  = hot_base;
      cold_addr_d = cold_base;
    end else if (issue) begin
      if (!d_last) begin
        d_d         = d_q + c_cnt_one;
        hot_addr_d  = hot_addr_q + c_addr_one;
        cold_addr_d = cold_addr_q + c_addr_one;
      end else begin
        d_d = c_cnt_zero;
        if (!c_last) begin
          // Same hot vector against the next cold vector; cold set is contiguous
          c_d         = c_q + c_cnt_one;
          hot_addr_d  = hot_row_q;
          cold_addr_d = cold_addr_q + c_addr_one;
        end else begin
          // Next hot vector starts right after the last chunk of this one
          c_d         = c_cnt_zero;
          h_d         = h_q + c_cnt_one;
          hot_row_d   = hot_addr_q + c_addr_one;
          hot_addr_d  = hot_addr_q + c_addr_one;
          cold_addr_d = cold_base_q;
        end
      end
    end
  end

  // In-flight read tracking and queue bookkeeping
  always_comb begin
    inflight_d  = issue;
    tag_first_d = issue ? (d_q == c_cnt_zero) : tag_first_q;
    tag_last_d  = issue ? d_last : tag_last_q;
    mem_d       = mem_q;
    if (q_wr) begin
      mem_d[wr_ptr_q] = entry_in;
    end
    wr_ptr_d = wr_ptr_q ^ q_wr;
    rd_ptr_d = rd_ptr_q ^ q_rd;
    count_d  = count_q + {1'b0, q_wr} - {1'b0, q_rd};
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cold_base_q <= '0;
      num_hot_q   <= '0;
      num_cold_q  <= '0;
      dim_q       <= '0;
      h_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      hot_row_q   <= '0;
      hot_addr_q  <= '0;
      cold_addr_q <= '0;
      inflight_q  <= 1'b0;
      tag_first_q <= 1'b0;
      tag_last_q  <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      cold_base_q <= cold_base_d;
      num_hot_q   <= num_hot_d;
      num_cold_q  <= num_cold_d;
      dim_q       <= dim_d;
      h_q         <= h_d;
      c_q         <= c_d;
      d_q         <= d_d;
      hot_row_q   <= hot_row_d;
      hot_addr_q  <= hot_addr_d;
      cold_addr_q <= cold_addr_d;
      inflight_q  <= inflight_d;
      tag_first_q <= tag_first_d;
      tag_last_q  <= tag_last_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

`ifdef MLU_FEED_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles the MLU holds off a presented beat
  always_comb begin
    stall_d = stall_q;
    if ((state_q == c_st_idle) && start) begin
      stall_d = 32'd0;
    end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule
`default_nettype wire
